// File: rtl/qspi_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI-NOR responder.
package qspi_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, TX_REG, WR_DATA, IGNORE
  } state_e;

endpackage

// File: rtl/qspi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized value.
module qspi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  // shift the pin through the synchronizer and keep one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/qspi_target.sv
// SPI-NOR flash responder (1-1-1, mode 0) serving a byte-wide synchronous memory port.
module qspi_target
  import qspi_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
  parameter int          PROG_CYCLES = 1024,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              io0_i,
  output logic              io1_o,
  output logic              io1_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  output logic              wip,
  output logic              wel
);
  localparam int BUSY_W = $clog2(PROG_CYCLES + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, io0_s;
  logic unused_sclk_q, unused_cs_q, unused_io0_rise, unused_io0_fall;

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));

  // cs_n idles high, so its synchronizer resets high to avoid a phantom edge
  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n),
    .q(unused_cs_q), .rise(cs_rise), .fall(cs_fall));

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_io0 (
    .clk(clk), .rst_n(rst_n), .d(io0_i),
    .q(io0_s), .rise(unused_io0_rise), .fall(unused_io0_fall));

  state_e              state, state_d;
  logic [4:0]          bit_cnt;
  logic [2:0]          tx_cnt;
  logic [6:0]          rx_sr;
  logic [7:0]          rx_next;
  logic [6:0]          tx_sr;
  logic [7:0]          tx_byte;
  logic [7:0]          pref;
  logic                rd_pend;
  logic [ADDR_W-1:0]   addr;
  logic [BUSY_W-1:0]   busy_cnt;
  logic                is_pp, reg_is_id, set_wel, clr_wel, wrote_any;
  logic [1:0]          id_idx;

  assign rx_next  = {rx_sr, io0_s};
  assign mem_addr = addr;
  assign wip      = (busy_cnt != '0);
  assign io1_oe   = (state == RD_DATA) || (state == TX_REG);

  // page-program address step: offset wraps inside the 256-byte page
  function automatic logic [ADDR_W-1:0] page_inc(input logic [ADDR_W-1:0] a);
    logic [23:0] w;
    w      = 24'(a);
    w[7:0] = w[7:0] + 8'd1;
    return w[ADDR_W-1:0];
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next-state decode; a cs_n rise always wins and returns to IDLE
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: if (sclk_rise && bit_cnt == 5'd7) begin
        if (wip && rx_next != OP_RDSR) state_d = IGNORE;
        else begin
          case (rx_next)
            OP_READ:          state_d = ADDR;
            OP_PP:            state_d = wel ? ADDR : IGNORE;
            OP_RDSR, OP_RDID: state_d = TX_REG;
            default:          state_d = IGNORE;
          endcase
        end
      end
      ADDR: if (sclk_rise && bit_cnt == 5'd23) state_d = is_pp ? WR_DATA : RD_DATA;
      default: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // byte presented at the first fall of each output byte; status is sampled live
  always_comb begin
    tx_byte = 8'h00;
    if (state == RD_DATA) tx_byte = pref;
    else if (reg_is_id) begin
      case (id_idx)
        2'd0:    tx_byte = JEDEC_ID[23:16];
        2'd1:    tx_byte = JEDEC_ID[15:8];
        2'd2:    tx_byte = JEDEC_ID[7:0];
        default: tx_byte = 8'h00;
      endcase
    end else begin
      tx_byte[SR_WIP] = wip;
      tx_byte[SR_WEL] = wel;
    end
  end

  // datapath: shift registers, memory strobes, prefetch, status latches and busy timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      tx_cnt    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      pref      <= '0;
      rd_pend   <= 1'b0;
      addr      <= '0;
      busy_cnt  <= '0;
      is_pp     <= 1'b0;
      reg_is_id <= 1'b0;
      set_wel   <= 1'b0;
      clr_wel   <= 1'b0;
      wrote_any <= 1'b0;
      id_idx    <= '0;
      wel       <= 1'b0;
      io1_o     <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      rd_pend   <= mem_rd_en;
      if (rd_pend)   pref <= mem_rdata;
      if (mem_wr_en) addr <= page_inc(addr);
      if (busy_cnt != '0) busy_cnt <= busy_cnt - BUSY_W'(1);

      if (cs_fall && state == IDLE) begin
        bit_cnt   <= '0;
        tx_cnt    <= '0;
        id_idx    <= '0;
        set_wel   <= 1'b0;
        clr_wel   <= 1'b0;
        wrote_any <= 1'b0;
        io1_o     <= 1'b0;
      end

      if (sclk_rise) begin
        rx_sr   <= rx_next[6:0];
        bit_cnt <= bit_cnt + 5'd1;
        unique case (state)
          CMD: if (bit_cnt == 5'd7) begin
            bit_cnt   <= '0;
            is_pp     <= (rx_next == OP_PP);
            reg_is_id <= (rx_next == OP_RDID);
            set_wel   <= (rx_next == OP_WREN) && !wip;
            clr_wel   <= (rx_next == OP_WRDI) && !wip;
          end
          ADDR: begin
            addr <= {addr[ADDR_W-2:0], io0_s};
            if (bit_cnt == 5'd23) begin
              bit_cnt   <= '0;
              mem_rd_en <= !is_pp;
            end
          end
          RD_DATA: if (bit_cnt == 5'd7) begin
            // prefetch the following byte while the current one shifts out
            bit_cnt   <= '0;
            addr      <= addr + ADDR_W'(1);
            mem_rd_en <= 1'b1;
          end
          WR_DATA: if (bit_cnt == 5'd7) begin
            bit_cnt   <= '0;
            mem_wr_en <= 1'b1;
            mem_wdata <= rx_next;
            wrote_any <= 1'b1;
          end
          default: ;
        endcase
      end

      if (sclk_fall && (state == RD_DATA || state == TX_REG)) begin
        tx_cnt <= tx_cnt + 3'd1;
        if (tx_cnt == 3'd0) begin
          io1_o <= tx_byte[7];
          tx_sr <= tx_byte[6:0];
          if (reg_is_id && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end else begin
          io1_o <= tx_sr[6];
          tx_sr <= {tx_sr[5:0], 1'b0};
        end
      end

      if (cs_rise) begin
        if (set_wel) wel <= 1'b1;
        if (clr_wel) wel <= 1'b0;
        if (state == WR_DATA && wrote_any) begin
          wel      <= 1'b0;
          busy_cnt <= BUSY_W'(PROG_CYCLES);
        end
        set_wel <= 1'b0;
        clr_wel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Scoreboard bench: SPI initiator driver, behavioural flash model, decoupled output monitor.
module tb_qspi_target;
  import qspi_pkg::*;

  localparam int          ADDR_W = 16;
  localparam int          PROG   = 1000;
  localparam int          SYNC   = 2;
  localparam logic [23:0] ID     = 24'hEF4017;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, io0_i = 1'b0;
  logic io1_o, io1_oe, mem_rd_en, mem_wr_en, wip, wel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00, mem_wdata;

  always #5 clk = ~clk;

  qspi_target #(.ADDR_W(ADDR_W), .JEDEC_ID(ID), .PROG_CYCLES(PROG), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .io0_i(io0_i),
    .io1_o(io1_o), .io1_oe(io1_oe), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .wip(wip), .wel(wel));

  // memory attached to the DUT, and the model's own picture of flash contents
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  int n_total = 0, n_bad = 0;
  logic [7:0]  tx_q[$], pp_q[$], got_q[$], exp_rx_q[$];
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_wip_q[$];
  int          wip_len = 0;
  bit          m_wel = 0, m_wip = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(string nm, logic [31:0] act);
    n_total++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endfunction

  // monitor: pops expectations whenever the DUT produces something observable
  always @(negedge clk) begin
    if (!rst_n) wip_len = 0;
    else begin
      if (mem_wr_en) begin
        if (exp_wr_q.size() == 0) unexpected("wr", 32'({mem_addr, mem_wdata}));
        else chk("wr", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
      end
      if (mem_rd_en) begin
        if (exp_rd_q.size() == 0) unexpected("rd_addr", 32'(mem_addr));
        else chk("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
      end
      if (wip) wip_len++;
      else if (wip_len != 0) begin
        if (exp_wip_q.size() == 0) unexpected("wip_len", 32'(wip_len));
        else chk("wip_len", 32'(wip_len), 32'(exp_wip_q.pop_front()));
        wip_len = 0;
      end
    end
    while (got_q.size() > 0) begin
      if (exp_rx_q.size() == 0) unexpected("rx", 32'(got_q.pop_front()));
      else chk("rx", 32'(got_q.pop_front()), 32'(exp_rx_q.pop_front()));
    end
  end

  // one SPI byte (or its first nbits), mode 0: MISO sampled at the rise
  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      io0_i = d[7-i];
      repeat (4) @(posedge clk);
      r = {r[6:0], io1_o};
      sclk = 1'b1;
      repeat (4) @(posedge clk);
      sclk = 1'b0;
    end
  endtask

  // full transaction from tx_q; bytes from index skip on are handed to the monitor
  task automatic txn(input int skip, input int last_bits);
    logic [7:0] r;
    int n;
    n = tx_q.size();
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    for (int k = 0; k < n; k++) begin
      spi_byte(tx_q[k], (k == n - 1) ? last_bits : 8, r);
      if (k >= skip && !(k == n - 1 && last_bits != 8)) got_q.push_back(r);
    end
    tx_q.delete();
    repeat (4) @(posedge clk);
    cs_n = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic do_wren();
    tx_q = {OP_WREN};
    txn(1, 8);
    if (!m_wip) m_wel = 1;
  endtask

  task automatic do_wrdi();
    tx_q = {OP_WRDI};
    txn(1, 8);
    if (!m_wip) m_wel = 0;
  endtask

  task automatic do_rdid(input int n);
    logic [7:0] idb [4];
    idb = '{ID[23:16], ID[15:8], ID[7:0], 8'h00};
    tx_q = {OP_RDID};
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'h00);
      exp_rx_q.push_back(idb[(i < 3) ? i : 3]);
    end
    txn(1, 8);
  endtask

  task automatic do_rdsr(input int n);
    tx_q = {OP_RDSR};
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'h00);
      exp_rx_q.push_back({6'b0, m_wel, m_wip});
    end
    txn(1, 8);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    tx_q = {OP_READ, a[23:16], a[15:8], a[7:0]};
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'h00);
      exp_rx_q.push_back(ref_mem[a[15:0] + 16'(i)]);
    end
    for (int i = 0; i <= n; i++) exp_rd_q.push_back(a[15:0] + 16'(i));
    txn(4, 8);
  endtask

  // page program of pp_q; last byte truncated to last_bits when last_bits < 8
  task automatic do_pp(input logic [23:0] a, input int last_bits);
    int full;
    logic [15:0] wa;
    bit ok;
    full = (last_bits == 8) ? pp_q.size() : pp_q.size() - 1;
    ok   = m_wel && !m_wip;
    tx_q = {OP_PP, a[23:16], a[15:8], a[7:0]};
    foreach (pp_q[i]) tx_q.push_back(pp_q[i]);
    if (ok) begin
      for (int i = 0; i < full; i++) begin
        wa = {a[15:8], a[7:0] + 8'(i)};
        ref_mem[wa] = pp_q[i];
        exp_wr_q.push_back({wa, pp_q[i]});
      end
      if (full > 0) exp_wip_q.push_back(PROG);
    end
    txn(tx_q.size(), last_bits);
    if (ok && full > 0) begin
      m_wel = 0;
      m_wip = 1;
    end
    pp_q.delete();
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (wip && i < PROG + 100) begin
      @(negedge clk);
      i++;
    end
    chk("wip_clear", 32'(wip), 32'(0));
    m_wip = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [23:0] a;
    int len;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    // every output held at 0 in reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst_io1_oe", 32'(io1_oe), 0);
    chk("rst_io1_o", 32'(io1_o), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_wip", 32'(wip), 0);
    chk("rst_wel", 32'(wel), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // identification, with the trailing zero byte
    do_rdid(4);

    // write-enable latch
    do_wren();
    chk("wel_set", 32'(wel), 32'(m_wel));
    do_rdsr(1);
    do_wrdi();
    chk("wel_clr", 32'(wel), 32'(m_wel));
    do_rdsr(1);

    // program 16 bytes and verify; protection while busy
    do_wren();
    for (int i = 0; i < 16; i++) pp_q.push_back(8'hA0 + 8'(i));
    do_pp(24'h001000, 8);
    chk("wel_after_pp", 32'(wel), 32'(m_wel));
    do_rdsr(2);
    do_wren();
    chk("wel_wren_busy", 32'(wel), 32'(m_wel));
    pp_q = {8'($urandom), 8'($urandom)};
    do_pp(24'h003000, 8);
    wait_idle();
    do_rdsr(1);
    do_read(24'h001000, 16);

    // program without write enable
    pp_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    do_pp(24'h004000, 8);

    // page-offset wrap on program, address wrap on read
    do_wren();
    pp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    do_pp(24'h0010FE, 8);
    wait_idle();
    do_read(24'h0010FE, 2);
    do_read(24'h001000, 2);
    do_read(24'h00FFFF, 2);

    // program with no complete byte changes nothing
    do_wren();
    pp_q = {8'h5C};
    do_pp(24'h005000, 3);
    chk("wel_pp0", 32'(wel), 32'(m_wel));
    chk("wip_pp0", 32'(wip), 32'(m_wip));

    // cs_n rise mid-byte: partial byte dropped, earlier byte kept
    pp_q = {8'h77, 8'h88};
    do_pp(24'h002000, 3);
    wait_idle();
    do_read(24'h002000, 2);

    // randomized program / read-back
    for (int t = 0; t < 3; t++) begin
      a   = {8'h00, 16'($urandom)};
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) pp_q.push_back(8'($urandom));
      do_wren();
      do_pp(a, 8);
      wait_idle();
      do_read(a, len);
    end

    // reset in the middle of a READ
    do_wren();
    exp_rd_q.push_back(16'h0100);
    exp_rd_q.push_back(16'h0101);
    exp_rx_q.push_back(ref_mem[16'h0100]);
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    tx_q = {OP_READ, 8'h00, 8'h01, 8'h00};
    foreach (tx_q[k]) spi_byte(tx_q[k], 8, r);
    tx_q.delete();
    spi_byte(8'h00, 8, r);
    got_q.push_back(r);
    spi_byte(8'h00, 3, r);
    chk("oe_before_rst", 32'(io1_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 32'(io1_oe), 0);
    chk("rst_mid_wel", 32'(wel), 0);
    m_wel = 0;
    m_wip = 0;
    cs_n  = 1'b1;
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    do_rdid(3);

    repeat (20) @(negedge clk);
    chk("wr_left", 32'(exp_wr_q.size()), 0);
    chk("rd_left", 32'(exp_rd_q.size()), 0);
    chk("rx_left", 32'(exp_rx_q.size()), 0);
    chk("wip_left", 32'(exp_wip_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
# qspi_target

Synthesizable SPI-NOR responder: the flash end of the link driven by `qspi_fsm`. It oversamples SCLK/CS_n/IO0 on the system clock, decodes a 1-1-1, mode-0, MSB-first command set (RDID, RDSR, WREN, WRDI, PP, READ), and serves data from a byte-wide synchronous memory port. It replaces the behavioural `qspi_device` model wherever a synthesizable target is needed, for example FPGA loopback and emulation of controller firmware.

## Interface
- `ADDR_W`, 16: memory address width, ≤24. A 3-byte address is always received; the low `ADDR_W` bits are used.
- `JEDEC_ID`, 24'hEF4017: RDID response, MSB byte first.
- `PROG_CYCLES`, 1024: `clk` cycles WIP stays set after a PP.
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs_n` and `io0_i` (≥2).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sclk`  in  1: SPI clock from the initiator (CPOL=0, CPHA=0).
- `cs_n`  in  1: chip select, active low.
- `io0_i`  in  1: MOSI.
- `io1_o`  out  1: MISO data.
- `io1_oe`  out  1: MISO output enable.
- `mem_addr`  out  ADDR_W: memory byte address.
- `mem_rd_en`  out  1: read strobe, one clk pulse.
- `mem_rdata`  in  8: read data, valid exactly 1 clk after `mem_rd_en`.
- `mem_wr_en`  out  1: write strobe, one clk pulse.
- `mem_wdata`  out  8: write data, valid with `mem_wr_en`.
- `wip`  out  1: status bit 0, write in progress.
- `wel`  out  1: status bit 1, write enable latch.

## Operation
- Edge detection runs on synchronized signals:
  - `sclk` rise: shift in `io0_i`.
  - `sclk` fall: shift out the next `io1_o` bit.
  - `cs_n` fall: start a transaction.
  - `cs_n` rise: end the transaction.
- FSM states: IDLE, CMD, ADDR, RD_DATA, TX_REG, WR_DATA, IGNORE.
  - IDLE → CMD on `cs_n` fall. Bit counter = 0.
  - CMD: 8 rises assemble the opcode, then:
    - 0x03 → ADDR.
    - 0x02 with WEL=1 → ADDR. With WEL=0 → IGNORE.
    - 0x05 → TX_REG (status).
    - 0x9F → TX_REG (ID).
    - 0x06: set WEL on `cs_n` rise.
    - 0x04: clear WEL on `cs_n` rise.
    - Any other opcode → IGNORE.
  - While WIP=1, every opcode except 0x05 → IGNORE.
  - ADDR: 24 rises; then READ → RD_DATA, PP → WR_DATA.
  - RD_DATA: on the 24th address rise, issue `mem_rd_en` at the captured address. The byte is loaded into the TX shift register before the next fall. Prefetch: on the rise completing bit 7 of each byte, read addr+1 (wraps at 2^ADDR_W). Reads are unlimited.
  - TX_REG:
    - Status: `{6'b0, WEL, WIP}`, repeated every byte and refreshed live.
    - ID: the 3 ID bytes, then 0x00 forever.
  - WR_DATA: each completed byte pulses `mem_wr_en` with `mem_addr` = page base | offset. The offset (`addr[7:0]`) increments and wraps within the 256-byte page.
  - IGNORE: `io1_oe`=0 until `cs_n` rise.
  - Any state → IDLE on `cs_n` rise.
- PP completion: on `cs_n` rise after PP with ≥1 full byte written, clear WEL, set WIP and load the busy counter with PROG_CYCLES. The counter decrements every clk; WIP clears when it reaches 0.
- A PP with 0 full data bytes leaves WEL and WIP unchanged.
- `cs_n` rise mid-byte: the partial byte is discarded and no write is issued for it. Earlier complete bytes stay written.
- `io1_oe`=1 only in RD_DATA and TX_REG while `cs_n` is low. It drops the clk after a synchronized `cs_n` rise.

## Timing
- Every output resets to 0.
- Constraint: SCLK high and low phases ≥4 clk each; `cs_n` high ≥4 clk between transactions.
- Input-to-action latency is SYNC_STAGES+1 clk after the pin edge.
- `io1_o` updates ≤SYNC_STAGES+2 clk after an SCLK fall, so it is stable before the next rise.
- First output bit is driven at the fall following the last command or address rise.
- Memory path:
  - `mem_rd_en` pulses for exactly 1 clk.
  - `mem_rdata` is captured at the next clk into a prefetch register.
  - `mem_wr_en` fires 1 clk after the 8th data rise.
- Busy counter:
  - Width is clog2(PROG_CYCLES+1).
  - WIP is high for exactly PROG_CYCLES clk, counted from the clk after the synchronized `cs_n` rise.
  - While WIP=1, `mem_wr_en` stays 0.
- Reset mid-transaction: immediate return to IDLE; WEL, WIP and the counter clear; `io1_oe`=0.

## Structure
- Package `qspi_pkg` holds:
  - opcode localparams: OP_READ 8'h03, OP_PP 8'h02, OP_RDSR 8'h05, OP_RDID 8'h9F, OP_WREN 8'h06, OP_WRDI 8'h04;
  - the state enum;
  - status bit indices SR_WIP=0 and SR_WEL=1.
- Sub-module `qspi_sync_edge` (SYNC_STAGES flops plus rise/fall pulses) is instantiated three times, for `sclk`, `cs_n` and `io0_i`.
- The top level holds the FSM, the bit/byte counters, the RX/TX shift registers, the prefetch register and the busy timer.

## Test plan
- **ID read:** RDID, 3 bytes, from `qspi_fsm` (SCLK = clk/8) → RX EF 40 17; a 4th byte reads 00.
- **WREN then RDSR:** WREN, then RDSR (1 byte) → 0x02. WRDI, then RDSR → 0x00.
- **Program and verify:** WREN; PP 16 B of A0..AF @0x001000.
  - During the PP: 16 `mem_wr_en` pulses at addresses 0x1000..0x100F.
  - RDSR polls read 0x01 for PROG_CYCLES clk, then 0x00.
  - READ 0x03 @0x001000, 16 B → A0..AF.
- **Protection:**
  - PP without WREN → zero `mem_wr_en`.
  - PP during WIP → zero `mem_wr_en`.
  - RDSR during WIP → 0x01.
- **Wrap cases:**
  - PP of 4 bytes @0x0010FE → writes to 0x10FE, 0x10FF, 0x1000, 0x1001.
  - READ @0xFFFF (ADDR_W=16), 2 bytes → mem addresses 0xFFFF then 0x0000.
- **Abort cases:**
  - `cs_n` rise after 3 bits of a PP data byte → that byte is not written.
  - `rst_n` asserted mid-READ → `io1_oe`=0 and `wel`=0 immediately; the next RDID is correct.
